// File: rtl/avalon_agent_pkg.sv
// Shared types and width helpers for the Avalon-MM burst RAM agent.
package avalon_agent_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_BURST = 2'd1,
    ST_RD_BURST = 2'd2
  } agent_state_t;

  localparam int unsigned AVL_ADDR_W = 32;

  function automatic int unsigned word_idx_w(input int unsigned mem_words);
    return $clog2(mem_words);
  endfunction

  function automatic int unsigned byte_off_w(input int unsigned data_bytes);
    return $clog2(data_bytes);
  endfunction

endpackage

// File: rtl/avalon_if.sv
// Avalon-MM bus bundle with the host and agent views.
interface avalon_if #(
  parameter int unsigned DATA_BYTES   = 4,
  parameter int unsigned BURSTCOUNT_W = 6
);
  logic                      clk;
  logic                      reset;
  logic [31:0]               address;
  logic [DATA_BYTES-1:0]     byteenable;
  logic                      read;
  logic                      write;
  logic [8*DATA_BYTES-1:0]   writedata;
  logic [BURSTCOUNT_W-1:0]   burstcount;
  logic [8*DATA_BYTES-1:0]   readdata;
  logic                      waitrequest;
  logic                      readdatavalid;

  modport agent (
    input  clk, reset, address, byteenable, read, write, writedata, burstcount,
    output readdata, waitrequest, readdatavalid
  );

  modport host (
    input  clk, reset, readdata, waitrequest, readdatavalid,
    output address, byteenable, read, write, writedata, burstcount
  );
endinterface

// File: rtl/avalon_sp_ram.sv
// Single-port byte-lane RAM with a registered, hold-on-idle read port.
module avalon_sp_ram
  import avalon_agent_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned MEM_WORDS  = 1024
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic [word_idx_w(MEM_WORDS)-1:0]     i_addr,
  input  logic                                 i_we,
  input  logic [DATA_BYTES-1:0]                i_be,
  input  logic [8*DATA_BYTES-1:0]              i_wdata,
  input  logic                                 i_re,
  output logic [8*DATA_BYTES-1:0]              o_rdata
);

  localparam int unsigned DW = 8 * DATA_BYTES;

  logic [DW-1:0] r_mem [MEM_WORDS];
  logic [DW-1:0] r_rdata;

  // Storage array carries no reset: contents survive bus reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int l = 0; l < int'(DATA_BYTES); l++) begin
        if (i_be[l]) begin
          r_mem[i_addr][8*l +: 8] <= i_wdata[8*l +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/avalon_burst_ram_agent.sv
// Avalon-MM responder serving single and burst accesses to an on-chip RAM.
module avalon_burst_ram_agent
  import avalon_agent_pkg::*;
#(
  parameter int unsigned DATA_BYTES   = 4,
  parameter int unsigned BURSTCOUNT_W = 6,
  parameter int unsigned MEM_WORDS    = 1024
) (
  avalon_if.agent avl
);

  localparam int unsigned IW = word_idx_w(MEM_WORDS);
  localparam int unsigned BO = byte_off_w(DATA_BYTES);
  localparam int unsigned DW = 8 * DATA_BYTES;

  agent_state_t            r_state, w_state_nxt;
  logic [IW-1:0]           r_addr, w_addr_nxt;
  logic [BURSTCOUNT_W-1:0] r_cnt, w_cnt_nxt;
  logic                    r_rvalid, w_rvalid_nxt;

  logic [AVL_ADDR_W-1:0]   w_addr_unused_bits;
  logic [IW-1:0]           w_idx;
  logic [BURSTCOUNT_W-1:0] w_n;
  logic                    w_wait;
  logic                    w_ram_we;
  logic                    w_ram_re;
  logic [IW-1:0]           w_ram_addr;
  logic [DW-1:0]           w_rdata;

  // Only the word-index field of the byte address is decoded.
  assign w_addr_unused_bits = avl.address;
  assign w_idx              = w_addr_unused_bits[BO +: IW];
  assign w_n                = (avl.burstcount == '0) ? BURSTCOUNT_W'(1) : avl.burstcount;
  assign w_wait             = avl.reset | (r_state == ST_RD_BURST);

  always_ff @(posedge avl.clk or posedge avl.reset) begin
    if (avl.reset) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_addr   <= w_addr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rvalid <= w_rvalid_nxt;
    end
  end

  // In RD_BURST r_cnt counts RAM reads still to issue; the beat on the bus lags by one.
  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_cnt_nxt    = r_cnt;
    w_rvalid_nxt = 1'b0;
    w_ram_we     = 1'b0;
    w_ram_re     = 1'b0;
    w_ram_addr   = r_addr;
    case (r_state)
      ST_IDLE: begin
        w_ram_addr = w_idx;
        if (avl.write && !w_wait) begin
          w_ram_we = 1'b1;
          if (w_n > BURSTCOUNT_W'(1)) begin
            w_addr_nxt  = w_idx + IW'(1);
            w_cnt_nxt   = w_n - BURSTCOUNT_W'(1);
            w_state_nxt = ST_WR_BURST;
          end
        end else if (avl.read && !w_wait) begin
          w_ram_re     = 1'b1;
          w_rvalid_nxt = 1'b1;
          w_addr_nxt   = w_idx + IW'(1);
          w_cnt_nxt    = w_n - BURSTCOUNT_W'(1);
          w_state_nxt  = ST_RD_BURST;
        end
      end
      ST_WR_BURST: begin
        if (avl.write) begin
          w_ram_we   = 1'b1;
          w_addr_nxt = r_addr + IW'(1);
          w_cnt_nxt  = r_cnt - BURSTCOUNT_W'(1);
          if (r_cnt == BURSTCOUNT_W'(1)) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_RD_BURST: begin
        if (r_cnt != '0) begin
          w_ram_re     = 1'b1;
          w_rvalid_nxt = 1'b1;
          w_addr_nxt   = r_addr + IW'(1);
          w_cnt_nxt    = r_cnt - BURSTCOUNT_W'(1);
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  avalon_sp_ram #(
    .DATA_BYTES (DATA_BYTES),
    .MEM_WORDS  (MEM_WORDS)
  ) u_ram (
    .i_clk   (avl.clk),
    .i_rst   (avl.reset),
    .i_addr  (w_ram_addr),
    .i_we    (w_ram_we),
    .i_be    (avl.byteenable),
    .i_wdata (avl.writedata),
    .i_re    (w_ram_re),
    .o_rdata (w_rdata)
  );

  assign avl.readdata      = w_rdata;
  assign avl.waitrequest   = w_wait;
  assign avl.readdatavalid = r_rvalid;

endmodule

// File: tb/tb_avalon_burst_ram_agent.sv
// Randomized and directed bench for avalon_burst_ram_agent against a word-array memory model.
module tb_avalon_burst_ram_agent;

  localparam int unsigned DB  = 4;
  localparam int unsigned BCW = 6;
  localparam int          MW  = 1024;

  avalon_if #(.DATA_BYTES(DB), .BURSTCOUNT_W(BCW)) bus ();

  avalon_burst_ram_agent #(
    .DATA_BYTES   (DB),
    .BURSTCOUNT_W (BCW),
    .MEM_WORDS    (MW)
  ) dut (
    .avl (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] mem_m [MW];
  logic [31:0] wd    [64];
  logic [3:0]  wb    [64];
  int          wgap  [64];
  bit          rd_noise;

  initial bus.clk = 1'b0;
  always #5 bus.clk = ~bus.clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge bus.clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.address    = $urandom;
    bus.burstcount = '0;
    bus.byteenable = '0;
    bus.writedata  = $urandom;
  endtask

  function automatic int eff_n(input int bc);
    return (bc == 0) ? 1 : bc;
  endfunction

  function automatic logic [31:0] word_addr(input int idx);
    logic [31:0] a;
    a       = $urandom;
    a[11:2] = 10'(idx);
    return a;
  endfunction

  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] be);
    for (int l = 0; l < 4; l++)
      if (be[l]) mem_m[idx][8*l +: 8] = d[8*l +: 8];
  endtask

  task automatic clear_gaps();
    for (int b = 0; b < 64; b++) wgap[b] = 0;
  endtask

  task automatic write_burst(input logic [31:0] addr, input int bc);
    int n;
    int idx;
    n   = eff_n(bc);
    idx = 32'(addr[11:2]);
    for (int b = 0; b < n; b++) begin
      if (b > 0) begin
        for (int g = 0; g < wgap[b]; g++) begin
          bus.write   = 1'b0;
          bus.read    = rd_noise ? 1'($urandom) : 1'b0;
          bus.address = $urandom;
          check("wr_gap_wait", 32'(bus.waitrequest), 32'd0);
          step();
        end
      end
      bus.write      = 1'b1;
      bus.read       = (b > 0 && rd_noise) ? 1'($urandom) : 1'b0;
      bus.address    = (b == 0) ? addr : $urandom;
      bus.burstcount = (b == 0) ? BCW'(bc) : BCW'($urandom);
      bus.byteenable = wb[b];
      bus.writedata  = wd[b];
      check("wr_wait", 32'(bus.waitrequest), 32'd0);
      model_write((idx + b) % MW, wd[b], wb[b]);
      step();
    end
    bus_idle();
  endtask

  task automatic read_burst(input logic [31:0] addr, input int bc);
    int n;
    int idx;
    n   = eff_n(bc);
    idx = 32'(addr[11:2]);
    bus.read       = 1'b1;
    bus.address    = addr;
    bus.burstcount = BCW'(bc);
    bus.byteenable = 4'($urandom);
    check("rd_accept_wait", 32'(bus.waitrequest), 32'd0);
    step();
    bus_idle();
    for (int k = 0; k < n; k++) begin
      check("rd_valid", 32'(bus.readdatavalid), 32'd1);
      check("rd_data", bus.readdata, mem_m[(idx + k) % MW]);
      check("rd_wait", 32'(bus.waitrequest), 32'd1);
      step();
    end
    check("rd_end_valid", 32'(bus.readdatavalid), 32'd0);
    check("rd_end_wait", 32'(bus.waitrequest), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int          idx;
    int          bc;

    rd_noise  = 1'b0;
    bus.reset = 1'b1;
    bus_idle();
    clear_gaps();
    repeat (3) @(posedge bus.clk);
    #1;
    check("rst_wait", 32'(bus.waitrequest), 32'd1);
    check("rst_valid", 32'(bus.readdatavalid), 32'd0);
    check("rst_rdata", bus.readdata, 32'd0);
    bus.reset = 1'b0;
    #1;
    check("post_rst_wait", 32'(bus.waitrequest), 32'd0);

    // Bring every word to a known value so any read can be checked.
    for (int blk = 0; blk < 32; blk++) begin
      for (int b = 0; b < 64; b++) begin
        wd[b]   = $urandom;
        wb[b]   = 4'hF;
        wgap[b] = $urandom_range(0, 1);
      end
      write_burst(word_addr(blk * 32), 32);
    end
    clear_gaps();

    wd[0] = 32'hDEADBEEF; wb[0] = 4'hF;
    write_burst(32'h0000_0010, 1);
    read_burst(32'h0000_0010, 1);

    wd[0] = 32'h11223344; wb[0] = 4'hF;
    write_burst(32'h0000_0020, 1);
    wd[0] = 32'hAABBCCDD; wb[0] = 4'h5;
    write_burst(32'h0000_0020, 1);
    read_burst(32'h0000_0020, 1);

    for (int b = 0; b < 4; b++) begin
      wd[b] = 32'(b + 1);
      wb[b] = 4'hF;
    end
    wgap[2] = 2;
    write_burst(32'h0000_0040, 4);
    clear_gaps();
    read_burst(32'h0000_0040, 4);

    wd[0] = 32'hAAAA_0001; wd[1] = 32'hBBBB_0002; wd[2] = 32'hCCCC_0003;
    wb[0] = 4'hF; wb[1] = 4'hF; wb[2] = 4'hF;
    write_burst(32'h0000_0FFC, 3);
    read_burst(32'h0000_0FFC, 3);
    read_burst(32'h0000_0000, 2);

    // Back-to-back reads with read held high across the first burst.
    bus.read = 1'b1; bus.address = 32'h0000_0040; bus.burstcount = BCW'(2);
    check("b2b_acc0_wait", 32'(bus.waitrequest), 32'd0);
    step();
    for (int k = 0; k < 2; k++) begin
      check("b2b_first_valid", 32'(bus.readdatavalid), 32'd1);
      check("b2b_first_data", bus.readdata, mem_m[16 + k]);
      check("b2b_first_wait", 32'(bus.waitrequest), 32'd1);
      step();
    end
    check("b2b_acc1_wait", 32'(bus.waitrequest), 32'd0);
    check("b2b_gap_valid", 32'(bus.readdatavalid), 32'd0);
    step();
    bus_idle();
    for (int k = 0; k < 2; k++) begin
      check("b2b_second_valid", 32'(bus.readdatavalid), 32'd1);
      check("b2b_second_data", bus.readdata, mem_m[16 + k]);
      step();
    end
    check("b2b_end_valid", 32'(bus.readdatavalid), 32'd0);

    // Read and write together: write lands, read gets no response.
    bus.read = 1'b1; bus.write = 1'b1; bus.address = 32'h0000_0080;
    bus.burstcount = BCW'(1); bus.byteenable = 4'hF; bus.writedata = 32'h5A5A_C3C3;
    model_write(32, 32'h5A5A_C3C3, 4'hF);
    step();
    bus_idle();
    for (int k = 0; k < 3; k++) begin
      check("rw_err_valid", 32'(bus.readdatavalid), 32'd0);
      check("rw_err_wait", 32'(bus.waitrequest), 32'd0);
      step();
    end
    read_burst(32'h0000_0080, 1);

    // Reset in the middle of an 8-beat read.
    bus.read = 1'b1; bus.address = 32'h0000_0100; bus.burstcount = BCW'(8);
    step();
    bus_idle();
    for (int k = 0; k < 3; k++) begin
      check("rstmid_valid", 32'(bus.readdatavalid), 32'd1);
      check("rstmid_data", bus.readdata, mem_m[64 + k]);
      if (k < 2) step();
    end
    #2;
    bus.reset = 1'b1;
    #1;
    check("rstmid_drop_valid", 32'(bus.readdatavalid), 32'd0);
    check("rstmid_wait", 32'(bus.waitrequest), 32'd1);
    check("rstmid_rdata", bus.readdata, 32'd0);
    step();
    step();
    bus.reset = 1'b0;
    #1;
    check("rstmid_rel_wait", 32'(bus.waitrequest), 32'd0);
    for (int k = 0; k < 6; k++) begin
      check("rstmid_no_beat", 32'(bus.readdatavalid), 32'd0);
      step();
    end
    read_burst(32'h0000_0104, 8);

    // Maximum-length burst crossing the top of the RAM.
    for (int b = 0; b < 64; b++) begin
      wd[b]   = $urandom;
      wb[b]   = 4'($urandom);
      wgap[b] = $urandom_range(0, 1);
    end
    write_burst(word_addr(1000), 63);
    read_burst(word_addr(1000), 63);

    rd_noise = 1'b1;
    for (int i = 0; i < 60; i++) begin
      idx = ($urandom % 4 == 0) ? 1016 + int'($urandom % 8) : int'($urandom % MW);
      a   = word_addr(idx);
      bc  = $urandom_range(0, 9);
      if ($urandom % 2 == 0) begin
        for (int b = 0; b < 64; b++) begin
          wd[b]   = $urandom;
          wb[b]   = 4'($urandom);
          wgap[b] = $urandom_range(0, 2);
        end
        write_burst(a, bc);
      end else begin
        read_burst(a, bc);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/avalon_burst_ram_agent.md
# avalon_burst_ram_agent

Avalon-MM agent (responder) holding a byte-enabled on-chip RAM. It answers single and burst reads and writes issued by any host on the team's `avalon_if` bus. It sits behind the interconnect as the target end of the `agent` modport and serves as the standard memory model and on-chip scratch memory for host-side blocks.

## Interface
Parameters:
- `DATA_BYTES`, 4: bytes per data word. Must match the bus.
- `BURSTCOUNT_W`, 6: burstcount width. Must match the bus.
- `MEM_WORDS`, 1024: RAM depth in words. Power of two, at least 2.

Ports: a single port `avl` of type `avalon_if.agent`. Signals are listed as seen by the block.
- `clk`, input, 1: the single clock. All logic is rising-edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `address`, input, 32: byte address. Word index = `address[$clog2(DATA_BYTES) +: $clog2(MEM_WORDS)]`. All other bits are ignored.
- `byteenable`, input, DATA_BYTES: write lane mask. Ignored for reads.
- `read`, input, 1: read command.
- `write`, input, 1: write beat.
- `writedata`, input, 8*DATA_BYTES: write data.
- `burstcount`, input, BURSTCOUNT_W: beats in the burst. Sampled on the first beat only.
- `readdata`, output, 8*DATA_BYTES: read data. Qualified by `readdatavalid`.
- `waitrequest`, output, 1: command stall.
- `readdatavalid`, output, 1: one read beat is present on `readdata`.

## Operation
- States: `IDLE`, `WR_BURST`, `RD_BURST`.
- Registers:
  - `addr_q`: word index.
  - `cnt_q`: beats remaining.
- `waitrequest = reset | (state == RD_BURST)`. It is never asserted in `IDLE` or `WR_BURST`.
- Command acceptance: `(read | write) & !waitrequest`.
- IDLE, write accepted:
  - Beat 0 is written to the word at `address`. Lanes are masked by `byteenable`.
  - Effective count N = `burstcount`. N = 0 is treated as 1.
  - If N > 1: `addr_q = index + 1`, `cnt_q = N - 1`, go to `WR_BURST`. Otherwise stay in `IDLE`.
- WR_BURST:
  - Each cycle with `write = 1` writes to `addr_q` (masked), increments `addr_q`, and decrements `cnt_q`.
  - `address` and `burstcount` are ignored during the burst.
  - `write = 0` cycles are gaps and change no state.
  - `read` is ignored during the burst.
  - Return to `IDLE` after the beat that takes `cnt_q` to 0.
- IDLE, read accepted (and `write = 0`):
  - Latch the start index and N (0 is treated as 1).
  - Go to `RD_BURST`. The block issues N RAM reads at consecutive word indices.
- RD_BURST:
  - One beat per cycle, contiguous with no gaps. There is no read backpressure on Avalon.
  - Return to `IDLE` in the cycle after the last `readdatavalid`.
- `read` and `write` both high in `IDLE` is a protocol error. The write is performed and the read is dropped, with no response.
- Address arithmetic is modulo `MEM_WORDS`. A burst crossing the top of the RAM wraps to index 0.
- RAM contents are undefined after power-up and are not cleared by `reset`.

## Timing
- Reset values:
  - `waitrequest = 1` while `reset` is high.
  - `readdatavalid = 0`, `readdata = 0`, state `IDLE`, counters 0.
- Reset mid-burst aborts immediately. `readdatavalid` drops asynchronously and no further beats are issued. Writes already performed persist.
- Write latency: data written at the edge closing the accepting cycle. A read accepted in the next cycle returns the new data.
- Read latency: command accepted in cycle T gives `readdatavalid = 1` in cycles T+1 … T+N.
- `waitrequest = 1` in cycles T+1 … T+N. The next command can be accepted no earlier than cycle T+N+1.
- `readdata` holds its last value when `readdatavalid = 0`.
- Maximum burst: 2^BURSTCOUNT_W − 1 beats.

## Structure
- Package `avalon_agent_pkg`:
  - State enum typedef `agent_state_t`.
  - Localparam helper for word-index width (`$clog2(MEM_WORDS)`) and byte-offset width (`$clog2(DATA_BYTES)`).
- Sub-module `avalon_sp_ram`: single-port RAM with `DATA_BYTES` byte-lane write enables and a registered read port. One access per cycle is sufficient because read and write states are exclusive.
- The top level contains the FSM, the address counter and the beat counter.

## Test plan
- Single write then single read: write 0xDEADBEEF to 0x10 with byteenable 0xF, then read 0x10 with burstcount 1. Required: `readdatavalid` for exactly 1 cycle, one cycle after acceptance, with `readdata` = 0xDEADBEEF.
- Byte-enable: write 0x11223344 to 0x20 (be 0xF), then 0xAABBCCDD (be 0x5). Required: read returns 0x11BB33DD.
- Write burst with gaps: burstcount 4 at 0x40, data 1..4, `write` low for 2 cycles between beats 2 and 3. Required: a read burst of 4 from 0x40 returns 1, 2, 3, 4 on 4 consecutive cycles. `waitrequest` is high for exactly those 4 cycles.
- Wrap-around: MEM_WORDS = 1024, write burst of 3 at byte address 0xFFC (word 1023), data A, B, C. Required: words 1023, 0 and 1 hold A, B, C.
- Back-to-back reads: read burst 2 accepted at T, and `read` held high. Required: the second command is accepted at T+3, with no overlap of `readdatavalid` runs.
- Reset mid-read: assert `reset` during beat 3 of an 8-beat read. Required: `readdatavalid` = 0 immediately and no further beats. After release, a new read is accepted in `IDLE` with correct data.
